// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one synchronous single-port RAM between two 4-phase requesters
module ram_port_arbiter #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  grant
);
  typedef enum logic [2:0] {IDLE, WR, RD1, RD2, ACK} state_t;
  state_t                 state;
  logic [SYNC_STAGES-1:0] sync0, sync1;
  logic                   req_s0, req_s1, rr, next_grant;
  assign req_s0     = sync0[SYNC_STAGES-1];
  assign req_s1     = sync1[SYNC_STAGES-1];
  assign next_grant = (req_s0 & req_s1) ? rr : req_s1;
  assign ram_cs     = (state == WR) || (state == RD1) || (state == RD2);
  assign ram_we     = (state == WR);
  assign ram_oe     = (state == RD2);
  assign busy       = (state != IDLE);
  assign ram_addr   = grant ? addr1 : addr0;
  assign ram_wdata  = grant ? wdata1 : wdata0;
  // bring the asynchronous requests into the clk domain
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= {sync0[SYNC_STAGES-2:0], req0};
      sync1 <= {sync1[SYNC_STAGES-2:0], req1};
    end
  // arbitrate, sequence the RAM access, then hold ack until the served request drops
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state  <= IDLE;
      grant  <= 1'b0;
      rr     <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      case (state)
        IDLE: if (req_s0 | req_s1) begin
          grant <= next_grant;
          rr    <= ~next_grant;
          state <= (next_grant ? we1 : we0) ? WR : RD1;
        end
        WR: begin
          ack0  <= ~grant;
          ack1  <= grant;
          state <= ACK;
        end
        RD1: state <= RD2;
        RD2: begin
          if (grant) rdata1 <= ram_rdata;
          else rdata0 <= ram_rdata;
          ack0  <= ~grant;
          ack1  <= grant;
          state <= ACK;
        end
        ACK: if (!(grant ? req_s1 : req_s0)) begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
